tcb_arb2: RTL and testbench

Two-port round-robin arbiter that shares one TCB subordinate (the unified instruction/data memory) between two TCB managers, typically the instruction-fetch port (port 0) and the load/store port (port 1) of a single-memory RISC-V core. It forwards one granted request per cycle, holds the grant across stalled transfers, and routes read data returned `DLY` cycles later to the manager that issued the request. It sits between the core's bus ports and `tcb_dec`/`mem`.

---
 rtl/tcb_arb2_if.sv | 27 ++
 rtl/tcb_arb2.sv | 137 +++++++++++++
 tb/tb_tcb_arb2.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcb_arb2_if.sv
// tcb_if: TCB bus bundle (request, write data, read data, handshake).
// Modports: man drives the request side, sub answers with rdt/rdy.
interface tcb_if #(
  parameter int AW = 22,
  parameter int DW = 32,
  parameter int BW = DW/8
);

  logic          vld;
  logic          wen;
  logic [AW-1:0] adr;
  logic [BW-1:0] ben;
  logic [DW-1:0] wdt;
  logic [DW-1:0] rdt;
  logic          rdy;

  modport man (
    output vld, wen, adr, ben, wdt,
    input  rdt, rdy
  );

  modport sub (
    input  vld, wen, adr, ben, wdt,
    output rdt, rdy
  );

endinterface

// File: rtl/tcb_arb2.sv
// tcb_arb2: two-port round-robin arbiter sharing one TCB subordinate.
// Ports: clk, rst (async, active-high), s[1:0] manager-side TCB ports, m shared TCB port.
module tcb_arb2 #(
  parameter int AW  = 22,
  parameter int DW  = 32,
  parameter int BW  = DW/8,
  parameter int DLY = 1
) (
  input  logic clk,
  input  logic rst,
  tcb_if.sub   s [1:0],
  tcb_if.man   m
);

  logic [1:0]    vld;
  logic [1:0]    wen;
  logic [AW-1:0] adr [2];
  logic [BW-1:0] ben [2];
  logic [DW-1:0] wdt [2];
  logic          mrdy;
  logic [DW-1:0] mrdt;

  assign vld    = {s[1].vld, s[0].vld};
  assign wen    = {s[1].wen, s[0].wen};
  assign adr[0] = s[0].adr;
  assign adr[1] = s[1].adr;
  assign ben[0] = s[0].ben;
  assign ben[1] = s[1].ben;
  assign wdt[0] = s[0].wdt;
  assign wdt[1] = s[1].wdt;
  assign mrdy   = m.rdy;
  assign mrdt   = m.rdt;

  logic       pri;
  logic       lck;
  logic       lid;
  logic       pri_nxt;
  logic       lck_nxt;
  logic       lid_nxt;
  logic       gnt;
  logic       fwd;
  logic       hs;
  logic [1:0] rdy;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri <= 1'b0;
      lck <= 1'b0;
      lid <= 1'b0;
    end else begin
      pri <= pri_nxt;
      lck <= lck_nxt;
      lid <= lid_nxt;
    end
  end

  // next state: a stall pins the grant, a handshake
  // releases it and hands the next tie to the other port
  always_comb begin
    pri_nxt = pri;
    lck_nxt = lck;
    lid_nxt = lid;
    unique case (1'b1)
      hs: begin
        lck_nxt = 1'b0;
        pri_nxt = ~gnt;
      end
      (fwd && !mrdy): begin
        lck_nxt = 1'b1;
        lid_nxt = gnt;
      end
      default: ;
    endcase
  end

  // outputs: grant select and request forwarding
  always_comb begin
    gnt = pri;
    unique case (1'b1)
      lck:                    gnt = lid;
      (!lck && vld == 2'b01): gnt = 1'b0;
      (!lck && vld == 2'b10): gnt = 1'b1;
      default:                gnt = pri;
    endcase
    fwd      = vld[gnt] & ~rst;
    hs       = fwd & mrdy;
    rdy      = 2'b00;
    rdy[gnt] = mrdy & ~rst;
  end

  assign m.vld    = fwd;
  assign m.wen    = wen[gnt];
  assign m.adr    = adr[gnt];
  assign m.ben    = ben[gnt];
  assign m.wdt    = wdt[gnt];
  assign s[0].rdy = rdy[0];
  assign s[1].rdy = rdy[1];

  // read tag pipeline: tail says who owns m.rdt now
  logic push;
  logic tval;
  logic tid;

  assign push = hs & ~wen[gnt];

  generate
    if (DLY == 0) begin : g_comb
      assign tval = push;
      assign tid  = gnt;
    end else begin : g_pipe
      logic [DLY-1:0] rv;
      logic [DLY-1:0] ri;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rv <= '0;
          ri <= '0;
        end else begin
          rv[0] <= push;
          ri[0] <= gnt;
          for (int k = 1; k < DLY; k++) begin
            rv[k] <= rv[k-1];
            ri[k] <= ri[k-1];
          end
        end
      end

      assign tval = rv[DLY-1];
      assign tid  = ri[DLY-1];
    end
  endgenerate

  assign s[0].rdt = (tval && !tid) ? mrdt : '0;
  assign s[1].rdt = (tval &&  tid) ? mrdt : '0;

endmodule

// File: tb/tb_tcb_arb2.sv
// tb_tcb_arb2: directed bench for tcb_arb2, four instances with DLY 0..3.
// Shared stimulus; a cycle model checks all outputs every cycle.
module tb_tcb_arb2;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_vld [2];
  logic          s_wen [2];
  logic [AW-1:0] s_adr [2];
  logic [BW-1:0] s_ben [2];
  logic [DW-1:0] s_wdt [2];
  logic          m_rdy;
  logic [DW-1:0] m_rdt [ND];

  logic          o_mvld [ND];
  logic          o_mwen [ND];
  logic [AW-1:0] o_madr [ND];
  logic [BW-1:0] o_mben [ND];
  logic [DW-1:0] o_mwdt [ND];
  logic          o_rdy  [2*ND];
  logic [DW-1:0] o_rdt  [2*ND];

  for (genvar k = 0; k < ND; k++) begin : g_dut
    tcb_if #(.AW(AW), .DW(DW), .BW(BW)) sp [1:0] ();
    tcb_if #(.AW(AW), .DW(DW), .BW(BW)) mp ();
    for (genvar i = 0; i < 2; i++) begin : g_p
      assign sp[i].vld = s_vld[i];
      assign sp[i].wen = s_wen[i];
      assign sp[i].adr = s_adr[i];
      assign sp[i].ben = s_ben[i];
      assign sp[i].wdt = s_wdt[i];
      assign o_rdy[2*k+i] = sp[i].rdy;
      assign o_rdt[2*k+i] = sp[i].rdt;
    end
    assign mp.rdy    = m_rdy;
    assign mp.rdt    = m_rdt[k];
    assign o_mvld[k] = mp.vld;
    assign o_mwen[k] = mp.wen;
    assign o_madr[k] = mp.adr;
    assign o_mben[k] = mp.ben;
    assign o_mwdt[k] = mp.wdt;
    tcb_arb2 #(.AW(AW), .DW(DW), .BW(BW), .DLY(k)) dut (
      .clk (clk),
      .rst (rst),
      .s   (sp),
      .m   (mp)
    );
  end

  int nvec = 0;
  int nerr = 0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", n, act, exp);
    end
  endfunction

  // model state
  typedef struct packed {
    logic          v;
    logic          p;
    logic [DW-1:0] d;
  } rsp_t;

  logic          mpri;
  int            own;
  rsp_t          h [5];
  logic [DW-1:0] mem [int];
  int            cyc;
  bit            armed;

  logic          e_g;
  logic          e_vld;
  logic          e_wen;
  logic [AW-1:0] e_adr;
  logic [BW-1:0] e_ben;
  logic [DW-1:0] e_wdt;
  logic          e_rdy [2];
  logic [DW-1:0] e_rdt [2*ND];

  // staged stimulus for the next cycle
  logic          n_vld [2];
  logic          n_wen [2];
  logic [AW-1:0] n_adr [2];
  logic [BW-1:0] n_ben [2];
  logic [DW-1:0] n_wdt [2];
  logic          n_rdy;
  logic          n_rst;

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {10'h155, a};
  endfunction

  task automatic req(input int p, input logic v, input logic w,
                     input logic [AW-1:0] a, input logic [BW-1:0] b,
                     input logic [DW-1:0] d);
    n_vld[p] = v;
    n_wen[p] = w;
    n_adr[p] = a;
    n_ben[p] = b;
    n_wdt[p] = d;
  endtask

  task automatic tick();
    logic [DW-1:0] w;
    rsp_t r;
    @(posedge clk);
    #1;
    // outcome of the cycle that just ended
    if (!rst && e_vld) begin
      if (m_rdy) begin
        mpri = ~e_g;
        own  = -1;
        if (e_wen) begin
          w = rd(e_adr);
          for (int b = 0; b < BW; b++)
            if (e_ben[b]) w[8*b +: 8] = e_wdt[8*b +: 8];
          mem[int'(e_adr)] = w;
        end
      end else begin
        own = e_g ? 1 : 0;
      end
    end
    rst   = n_rst;
    m_rdy = n_rdy;
    for (int i = 0; i < 2; i++) begin
      s_vld[i] = n_vld[i];
      s_wen[i] = n_wen[i];
      s_adr[i] = n_adr[i];
      s_ben[i] = n_ben[i];
      s_wdt[i] = n_wdt[i];
    end
    cyc++;
    if (rst) begin
      mpri = 1'b0;
      own  = -1;
    end
    for (int j = 4; j > 0; j--) h[j] = h[j-1];
    if (rst)
      for (int j = 0; j < 5; j++) h[j] = '0;
    if (own >= 0)                e_g = (own == 1);
    else if (s_vld[0] != s_vld[1]) e_g = s_vld[1];
    else                         e_g = mpri;
    e_vld = !rst && s_vld[e_g];
    e_wen = s_wen[e_g];
    e_adr = s_adr[e_g];
    e_ben = s_ben[e_g];
    e_wdt = s_wdt[e_g];
    for (int i = 0; i < 2; i++)
      e_rdy[i] = !rst && m_rdy && (int'(e_g) == i);
    h[0].v = e_vld && m_rdy && !e_wen;
    h[0].p = e_g;
    h[0].d = rd(e_adr);
    for (int k = 0; k < ND; k++) begin
      r = h[k];
      m_rdt[k] = r.v ? r.d : (32'hBAD00000 + 32'(cyc % 4096) + 32'(k) * 32'h1000);
      for (int i = 0; i < 2; i++)
        e_rdt[2*k+i] = (r.v && int'(r.p) == i) ? r.d : '0;
    end
    @(negedge clk);
    #1;
  endtask

  // every-cycle compare against the model
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < ND; k++) begin
        chk($sformatf("mvld[%0d]", k), 32'(o_mvld[k]), 32'(e_vld));
        chk($sformatf("mwen[%0d]", k), 32'(o_mwen[k]), 32'(e_wen));
        chk($sformatf("madr[%0d]", k), 32'(o_madr[k]), 32'(e_adr));
        chk($sformatf("mben[%0d]", k), 32'(o_mben[k]), 32'(e_ben));
        chk($sformatf("mwdt[%0d]", k), o_mwdt[k], e_wdt);
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("rdy[%0d][%0d]", k, i), 32'(o_rdy[2*k+i]), 32'(e_rdy[i]));
          chk($sformatf("rdt[%0d][%0d]", k, i), o_rdt[2*k+i], e_rdt[2*k+i]);
        end
      end
    end
  end

  int c0;
  int c1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_vld[i] = 1'b0; s_wen[i] = 1'b0; s_adr[i] = '0;
      s_ben[i] = '0;   s_wdt[i] = '0;
      req(i, 1'b0, 1'b0, '0, '0, '0);
    end
    for (int k = 0; k < ND; k++) m_rdt[k] = '0;
    for (int j = 0; j < 5; j++) h[j] = '0;
    m_rdy = 1'b1;
    n_rdy = 1'b1;
    n_rst = 1'b1;
    mpri  = 1'b0;
    own   = -1;
    cyc   = 0;
    e_g = 1'b0; e_vld = 1'b0; e_wen = 1'b0;
    e_adr = '0; e_ben = '0; e_wdt = '0;
    mem[32'h10] = 32'hDEADBEEF;
    mem[32'h20] = 32'h00000011;
    mem[32'h21] = 32'h00000022;
    mem[32'h22] = 32'h00000033;
    mem[32'h31] = 32'h31313131;
    armed = 1'b1;

    // reset state with both ports requesting
    req(0, 1'b1, 1'b0, 22'h10, 4'hF, '0);
    req(1, 1'b1, 1'b0, 22'h20, 4'hF, '0);
    tick();
    chk("rst_mvld", 32'(o_mvld[1]), 32'd0);
    chk("rst_rdy0", 32'(o_rdy[2]), 32'd0);
    chk("rst_rdy1", 32'(o_rdy[3]), 32'd0);

    // single requester
    n_rst = 1'b0;
    req(1, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("single_adr", 32'(o_madr[1]), 32'h10);
    chk("single_vld", 32'(o_mvld[1]), 32'd1);
    req(0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("single_rdt0", o_rdt[2], 32'hDEADBEEF);
    chk("single_rdt1", o_rdt[3], 32'd0);

    // contention fairness from reset
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 8; i++) begin
      req(0, 1'b1, 1'b0, 22'(32'h100 + (i+1)/2), 4'hF, '0);
      req(1, 1'b1, 1'b0, 22'(32'h200 + i/2), 4'hF, '0);
      tick();
      chk("fair_gnt", 32'(o_rdy[2 + i%2]), 32'd1);
      chk("fair_oth", 32'(o_rdy[3 - i%2]), 32'd0);
      if (i > 0) begin
        c0 += (o_rdt[2] != 0) ? 1 : 0;
        c1 += (o_rdt[3] != 0) ? 1 : 0;
      end
    end
    req(0, 1'b0, 1'b0, '0, '0, '0);
    req(1, 1'b0, 1'b0, '0, '0, '0);
    tick();
    c0 += (o_rdt[2] != 0) ? 1 : 0;
    c1 += (o_rdt[3] != 0) ? 1 : 0;
    chk("fair_last", o_rdt[3], {10'h155, 22'h203});
    chk("fair_cnt0", 32'(c0), 32'd4);
    chk("fair_cnt1", 32'(c1), 32'd4);

    // stall lock on a port 1 write
    n_rdy = 1'b0;
    req(1, 1'b1, 1'b1, 22'h300, 4'hF, 32'h12345678);
    tick();
    chk("stall_adr", 32'(o_madr[1]), 32'h300);
    chk("stall_rdy0", 32'(o_rdy[2]), 32'd0);
    req(0, 1'b1, 1'b0, 22'h40, 4'hF, '0);
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("stall_adr", 32'(o_madr[1]), 32'h300);
      chk("stall_wdt", o_mwdt[1], 32'h12345678);
      chk("stall_rdy0", 32'(o_rdy[2]), 32'd0);
    end
    n_rdy = 1'b1;
    tick();
    chk("stall_done", 32'(o_rdy[3]), 32'd1);
    chk("stall_rdy0", 32'(o_rdy[2]), 32'd0);
    req(1, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("stall_next", 32'(o_rdy[2]), 32'd1);
    chk("stall_nadr", 32'(o_madr[1]), 32'h40);
    req(0, 1'b0, 1'b0, '0, '0, '0);
    tick();

    // latency routing on the DLY=3 instance
    req(0, 1'b1, 1'b0, 22'h20, 4'hF, '0);
    tick();
    req(0, 1'b0, 1'b0, '0, '0, '0);
    req(1, 1'b1, 1'b0, 22'h21, 4'hF, '0);
    tick();
    req(1, 1'b0, 1'b0, '0, '0, '0);
    req(0, 1'b1, 1'b0, 22'h22, 4'hF, '0);
    tick();
    req(0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("lat_n3", o_rdt[6], 32'h11);
    tick();
    chk("lat_n4", o_rdt[7], 32'h22);
    tick();
    chk("lat_n5", o_rdt[6], 32'h33);

    // write produces no response
    req(1, 1'b1, 1'b1, 22'h30, 4'b1100, 32'hCAFE0000);
    tick();
    chk("wr_ben", 32'(o_mben[1]), 32'hC);
    chk("wr_wen", 32'(o_mwen[1]), 32'd1);
    req(1, 1'b0, 1'b0, '0, '0, '0);
    req(0, 1'b1, 1'b0, 22'h31, 4'hF, '0);
    tick();
    chk("wr_nrsp0", o_rdt[2], 32'd0);
    chk("wr_nrsp1", o_rdt[3], 32'd0);
    req(0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("wr_rd0", o_rdt[2], 32'h31313131);
    chk("wr_rd1", o_rdt[3], 32'd0);

    // reset with reads in flight
    req(0, 1'b1, 1'b0, 22'h10, 4'hF, '0);
    tick();
    req(0, 1'b1, 1'b0, 22'h11, 4'hF, '0);
    n_rst = 1'b1;
    tick();
    chk("mid_mvld", 32'(o_mvld[2]), 32'd0);
    chk("mid_rdy", 32'(o_rdy[4]), 32'd0);
    chk("mid_rdt1", o_rdt[2], 32'd0);
    n_rst = 1'b0;
    req(0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("mid_drop", o_rdt[4], 32'd0);
    tick();
    req(0, 1'b1, 1'b0, 22'h50, 4'hF, '0);
    req(1, 1'b1, 1'b0, 22'h60, 4'hF, '0);
    tick();
    chk("mid_tie0", 32'(o_rdy[4]), 32'd1);
    chk("mid_tie1", 32'(o_rdy[5]), 32'd0);
    req(0, 1'b0, 1'b0, '0, '0, '0);
    req(1, 1'b0, 1'b0, '0, '0, '0);
    for (int j = 0; j < 5; j++) tick();

    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
